// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio -- memory-mapped 8N1 UART transmitter with a small transmit FIFO.
//
// Register window (decoded on addr[3:2]):
//   0 TXDATA  write pushes wd[7:0] into the FIFO, reads return 0
//   1 STATUS  read: bit0 busy, bit1 full, bit2 empty, bits[7:3] count,
//             bit8 overflow (sticky); write with wd[8]=1 clears overflow
//   2,3       reserved: reads 0, writes ignored
//
// Ports:
//   clk   system clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   en    peripheral select from address decode
//   we    write enable, qualified by en
//   addr  byte offset within the UART window
//   wd    write data
//   rd    combinational read data (0 unless en=1 and we=0)
//   tx    registered serial output, idle high
module uart_tx_mmio #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx
);

  localparam int          PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW       = PW + 1;
  localparam logic [15:0] BAUD_MAX = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          r_state;
  logic [15:0]     r_baud;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_tx;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;

  logic            w_wr_acc;
  logic            w_rd_acc;
  logic            w_sel_tx;
  logic            w_sel_st;
  logic            w_empty;
  logic            w_full;
  logic            w_baud_end;
  logic            w_pop;
  logic            w_push_req;
  logic            w_push;
  logic            w_drop;
  logic [2:0]      w_next_bit;
  logic [31:0]     w_status;
  logic            w_unused;

  assign w_wr_acc   = en & we;
  assign w_rd_acc   = en & ~we;
  assign w_sel_tx   = (addr[3:2] == 2'd0);
  assign w_sel_st   = (addr[3:2] == 2'd1);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_baud_end = (r_baud == BAUD_MAX);
  assign w_next_bit = r_bit + 3'd1;

  // The FSM takes the head either from IDLE or at the very end of STOP, so
  // back-to-back frames have no idle gap.
  assign w_pop = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_baud_end));

  // A pop on the same edge frees a slot, so a push to a full FIFO still lands.
  assign w_push_req = w_wr_acc & w_sel_tx;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  assign w_status = {23'd0, r_ovf, 5'(r_count), w_empty, w_full, (r_state != IDLE)};

  assign w_unused = &{1'b0, wd[31:9], addr[1:0]};

  always_comb begin
    rd = '0;
    if (w_rd_acc && w_sel_st) begin
      rd = w_status;
    end
  end

  assign tx = r_tx;

  // Transmit FIFO and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= wd[7:0];
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_wr_acc && w_sel_st && wd[8]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Serial framing FSM; tx is registered and changes only on state/bit steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          r_tx   <= 1'b1;
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_state <= START;
            r_tx    <= 1'b0;
          end
        end
        START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_bit   <= '0;
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit <= w_next_bit;
              r_tx  <= r_shift[w_next_bit];
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
              r_state <= START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_baud <= r_baud + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_baud  <= '0;
          r_bit   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio -- directed self-checking bench for uart_tx_mmio
// (CLK_DIV=16, FIFO_DEPTH=4). Inputs change 1 time unit after a rising edge;
// outputs are sampled in that same quiet window.
module tb_uart_tx_mmio;

  localparam int CLK_DIV = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_mmio #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .we  (we),
    .addr(addr),
    .wd  (wd),
    .rd  (rd),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    en = 1'b1; we = 1'b1; addr = a; wd = d;
    step();
    en = 1'b0; we = 1'b0; addr = 4'h0; wd = '0;
  endtask

  task automatic rd_status(output logic [31:0] v);
    en = 1'b1; we = 1'b0; addr = 4'h4;
    #1;
    v = rd;
    en = 1'b0; addr = 4'h0;
  endtask

  // Expected line level c cycles after the edge that starts a frame.
  function automatic logic fbit(input logic [7:0] b, input int c);
    int s;
    s = c / CLK_DIV;
    if (s == 0) return 1'b0;
    if (s >= 9) return 1'b1;
    return b[s-1];
  endfunction

  // Checks tx for frame cycles first..last, advancing one edge after each.
  task automatic expect_bits(input string tag, input logic [7:0] b, input int first, input int last);
    for (int c = first; c <= last; c++) begin
      chk($sformatf("%s_c%0d", tag, c), {31'd0, tx}, {31'd0, fbit(b, c)});
      step();
    end
  endtask

  logic [31:0] st;

  initial begin
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = 4'h0; wd = '0;
    step();
    step();
    chk("reset_tx", {31'd0, tx}, 32'd1);
    rd_status(st);
    chk("reset_status", st, 32'h004);
    rst = 1'b0;
    step();

    // Unselected write, reserved accesses, and rd gating.
    en = 1'b0; we = 1'b1; addr = 4'h0; wd = 32'hAB;
    #1;
    chk("unsel_rd", rd, 32'h0);
    step();
    en = 1'b0; we = 1'b0; wd = '0;
    rd_status(st);
    chk("unsel_no_push", st, 32'h004);
    wr(4'h8, 32'h5A);
    rd_status(st);
    chk("reserved_wr_ignored", st, 32'h004);
    en = 1'b1; we = 1'b0; addr = 4'hC;
    #1;
    chk("reserved_rd", rd, 32'h0);
    addr = 4'h0;
    #1;
    chk("txdata_rd", rd, 32'h0);
    we = 1'b1; addr = 4'h4;
    #1;
    chk("rd_during_we", rd, 32'h0);
    en = 1'b0; we = 1'b0; addr = 4'h0;
    step();
    chk("idle_tx", {31'd0, tx}, 32'd1);

    // Single byte 0x55: one-edge latency then a 160-cycle frame.
    wr(4'h0, 32'hFFFF_FF55);
    chk("lat_tx_still_high", {31'd0, tx}, 32'd1);
    rd_status(st);
    chk("lat_status_queued", st, 32'h008);
    step();
    rd_status(st);
    chk("frame55_status_busy", st, 32'h005);
    expect_bits("f55", 8'h55, 0, 159);
    rd_status(st);
    chk("frame55_done_status", st, 32'h004);
    chk("frame55_done_tx", {31'd0, tx}, 32'd1);

    // Six writes on consecutive edges: fifth queued fills FIFO, sixth dropped.
    wr(4'h0, 32'hA3);
    wr(4'h0, 32'h3C);
    wr(4'h0, 32'h01);
    wr(4'h0, 32'h80);
    wr(4'h0, 32'hFF);
    wr(4'h0, 32'h77);
    rd_status(st);
    chk("burst_full_ovf", st, 32'h123);
    wr(4'h4, 32'h100);
    rd_status(st);
    chk("ovf_cleared", st, 32'h023);
    expect_bits("bA3", 8'hA3, 5, 159);
    expect_bits("b3C", 8'h3C, 0, 159);
    expect_bits("b01", 8'h01, 0, 159);
    expect_bits("b80", 8'h80, 0, 159);
    expect_bits("bFF", 8'hFF, 0, 159);
    rd_status(st);
    chk("burst_done_status", st, 32'h004);

    // Full FIFO, write landing on the STOP-completion edge.
    wr(4'h0, 32'h5E);
    wr(4'h0, 32'h11);
    wr(4'h0, 32'h22);
    wr(4'h0, 32'h33);
    wr(4'h0, 32'h44);
    expect_bits("p5E", 8'h5E, 3, 158);
    chk("p5E_c159", {31'd0, tx}, 32'd1);
    wr(4'h0, 32'h99);
    rd_status(st);
    chk("pushpop_full_status", st, 32'h023);
    expect_bits("p11", 8'h11, 0, 159);
    expect_bits("p22", 8'h22, 0, 159);
    expect_bits("p33", 8'h33, 0, 159);
    expect_bits("p44", 8'h44, 0, 159);
    expect_bits("p99", 8'h99, 0, 159);
    rd_status(st);
    chk("pushpop_done_status", st, 32'h004);

    // Reset at cycle 40 with two bytes queued, alongside a TXDATA write.
    wr(4'h0, 32'hC0);
    wr(4'h0, 32'hC1);
    wr(4'h0, 32'hC2);
    expect_bits("rC0", 8'hC0, 1, 39);
    rst = 1'b1; en = 1'b1; we = 1'b1; addr = 4'h0; wd = 32'hE7;
    step();
    rst = 1'b0; en = 1'b0; we = 1'b0; wd = '0;
    chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    rd_status(st);
    chk("rst_mid_status", st, 32'h004);
    for (int i = 0; i < 200; i++) begin
      step();
      chk($sformatf("rst_quiet_%0d", i), {31'd0, tx}, 32'd1);
    end
    rd_status(st);
    chk("rst_final_status", st, 32'h004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
